hazard_sequencer: RTL and testbench

Central pipeline controller for the five-stage core. Each cycle it decides whether the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers hold, advance or flush. It drives PC enable and clearMemReq, and latches halt. Its inputs are memory-hit handshakes, load-use hazard fields and redirect requests, so the pipeline registers and PC hold no hazard logic of their own.

---
 rtl/hazard_sequencer.sv | 134 +++++++++++++
 tb/tb_hazard_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline controller for the five-stage core: decides per cycle whether each
// pipeline register holds, advances or flushes, and tracks halt and stall cycles.
module hazard_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_dREN,
    input  logic [4:0]       ex_wsel,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_redirect,
    input  logic             id_jump,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             clear_mem_req,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state;
    logic   dserved;
    logic   dreq;
    logic   lu;
    logic   advance;
    logic   halt_entry;

    assign dreq       = mem_dREN | mem_dWEN;
    assign lu         = ex_dREN && (ex_wsel != 5'd0) &&
                        ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
    assign advance    = ihit && (!dreq || dhit || dserved) && (state != HALT);
    assign halt_entry = wb_halt && (state != HALT);

    assign clear_mem_req = dserved && !RST;

    // Redirect outranks load-use: the dependent instruction in ID is squashed anyway.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!RST) begin
            if (halt_entry) begin
                exmem_flush = 1'b1;
            end else if (advance) begin
                exmem_en = 1'b1;
                memwb_en = 1'b1;
                idex_en  = 1'b1;
                if (ex_redirect) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (lu) begin
                    idex_flush = 1'b1;
                end else if (id_jump) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            dserved     <= 1'b0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            if ((state != HALT) && !advance && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};

            if ((state == HALT) || halt_entry || advance)
                dserved <= 1'b0;
            else if (dhit)
                dserved <= 1'b1;

            if (halt_entry) begin
                state  <= HALT;
                halted <= 1'b1;
            end else begin
                case (state)
                    RUN: begin
                        if (dhit && !ihit)
                            state <= IWAIT;
                        else if (dreq && !dhit)
                            state <= DWAIT;
                    end
                    DWAIT: begin
                        if (dhit && !ihit)
                            state <= IWAIT;
                        else if (advance)
                            state <= RUN;
                    end
                    IWAIT: begin
                        if (ihit)
                            state <= RUN;
                    end
                    HALT: state <= HALT;
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: stimulus pushes hand-computed expectations
// into a queue and a negedge monitor pops and compares them.
module tb_hazard_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0, dhit = 1'b0, mem_dREN = 1'b0, mem_dWEN = 1'b0;
    logic        ex_dREN = 1'b0, id_uses_rt = 1'b0, ex_redirect = 1'b0;
    logic        id_jump = 1'b0, wb_halt = 1'b0;
    logic [4:0]  ex_wsel = 5'd0, id_rs = 5'd0, id_rt = 5'd0;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, clear_mem_req, halted;
    logic [31:0] stall_count;

    int checks   = 0;
    int failures = 0;

    // Output vector order: pc,ifid,idex,exmem,memwb en | ifid,idex,exmem flush | clr | halted
    localparam logic [9:0] NONE    = 10'b00000_000_0_0;
    localparam logic [9:0] ALL_EN  = 10'b11111_000_0_0;
    localparam logic [9:0] LU_OUT  = 10'b00111_010_0_0;
    localparam logic [9:0] REDIR   = 10'b11111_110_0_0;
    localparam logic [9:0] JUMP    = 10'b11111_100_0_0;
    localparam logic [9:0] CLR     = 10'b00000_000_1_0;
    localparam logic [9:0] ALL_CLR = 10'b11111_000_1_0;
    localparam logic [9:0] HENTRY  = 10'b00000_001_0_0;
    localparam logic [9:0] HALTED  = 10'b00000_000_0_1;

    typedef struct {
        string       name;
        logic [9:0]  outs;
        logic [31:0] stall;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    logic [9:0] act;

    hazard_sequencer #(.CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN),
        .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_redirect(ex_redirect), .id_jump(id_jump), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .clear_mem_req(clear_mem_req), .halted(halted),
        .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    task automatic apply_stimulus(input logic rst, input logic ih, input logic dh,
                                  input logic rd, input logic wr, input logic exr,
                                  input logic [4:0] ws, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic urt,
                                  input logic redir, input logic jmp, input logic hlt);
        @(posedge CLK);
        #1;
        RST = rst; ihit = ih; dhit = dh; mem_dREN = rd; mem_dWEN = wr;
        ex_dREN = exr; ex_wsel = ws; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_redirect = redir; id_jump = jmp; wb_halt = hlt;
    endtask

    task automatic check_output(input string name, input logic [9:0] outs,
                                input logic [31:0] stall);
        exp_t e;
        e.name  = name;
        e.outs  = outs;
        e.stall = stall;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            act = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, clear_mem_req, halted};
            checks++;
            if (act !== cur.outs) begin
                failures++;
                $display("[TB] FAIL %s outputs actual=%b required=%b", cur.name, act, cur.outs);
            end
            checks++;
            if (stall_count !== cur.stall) begin
                failures++;
                $display("[TB] FAIL %s stall_count actual=%0d required=%0d",
                         cur.name, stall_count, cur.stall);
            end
        end
    end

    initial begin
        //             rst ih dh rd wr exr ws    rs    rt    urt rdr jmp hlt
        apply_stimulus(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        apply_stimulus(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("reset_hold", NONE, 0);
        apply_stimulus(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("first_run", ALL_EN, 0);
        apply_stimulus(0, 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0);
        check_output("lu_rs", LU_OUT, 0);
        apply_stimulus(0, 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("lu_r0", ALL_EN, 0);
        apply_stimulus(0, 1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0);
        check_output("lu_rt_unused", ALL_EN, 0);
        apply_stimulus(0, 1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0);
        check_output("lu_rt_used", LU_OUT, 0);
        apply_stimulus(0, 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 0);
        check_output("redirect_over_lu", REDIR, 0);
        apply_stimulus(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        check_output("jump", JUMP, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        check_output("jump_no_ihit", NONE, 0);
        // Split hits: dhit two cycles before ihit
        apply_stimulus(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("split_c1", NONE, 1);
        apply_stimulus(0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("split_c2_dhit", NONE, 2);
        apply_stimulus(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("split_c3", CLR, 3);
        apply_stimulus(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("split_c4_ihit", ALL_CLR, 4);
        apply_stimulus(0, 1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("store_both_hits", ALL_EN, 4);
        apply_stimulus(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("no_dserved_residue", ALL_EN, 4);
        apply_stimulus(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0);
        check_output("dhit_with_redirect", REDIR, 4);
        // Reset while a served request is pending
        apply_stimulus(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("pre_reset_wait", NONE, 4);
        apply_stimulus(0, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("pre_reset_dhit", NONE, 5);
        apply_stimulus(1, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("reset_forces_zero", NONE, 6);
        apply_stimulus(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("after_reset_clean", ALL_EN, 0);
        // Halt
        apply_stimulus(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
        check_output("halt_entry", HENTRY, 0);
        apply_stimulus(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("halted_hits", HALTED, 1);
        apply_stimulus(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        check_output("halted_jump", HALTED, 1);
        apply_stimulus(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1);
        check_output("halted_wb_halt", HALTED, 1);
        apply_stimulus(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("halt_reset", HALTED, 1);
        apply_stimulus(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        check_output("after_halt_reset", ALL_EN, 0);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain pending actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
